blend_factor_stage: RTL and testbench
=====================================

# blend_factor_stage

Fragment blending front end for the framebuffer path. Accepts one fragment per cycle (source colour, destination colour, per-fragment tag) over a valid/ready handshake. Selects source and destination blend factors and feeds the existing 2-cycle ColorMixer to compute src·Fs + dst·Fd. Carries tag and valid alongside the mixer pipeline, then presents the saturated result to the framebuffer write stage over valid/ready.

## Interface
Parameters:
- SUB_PIXEL_WIDTH, 8, bits per colour channel; pixel is 4 channels: R = sub-pixel 3 (MSB), G = 2, B = 1, A = 0.
- TAG_WIDTH, 16, width of the opaque sideband (framebuffer index plus write mask), passed through unchanged.

Ports:
- aclk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- blend_enable  in  1  0: result is src unchanged; 1: blend.
- src_factor  in  4  source blend function; encoding in Operation.
- dst_factor  in  4  destination blend function; same encoding.
- s_valid  in  1  input fragment valid.
- s_ready  out  1  input accepted when s_valid && s_ready.
- s_src  in  4*SUB_PIXEL_WIDTH  source (fragment) colour.
- s_dst  in  4*SUB_PIXEL_WIDTH  destination (framebuffer) colour.
- s_tag  in  TAG_WIDTH  sideband.
- m_valid  out  1  result valid.
- m_ready  in  1  downstream ready.
- m_color  out  4*SUB_PIXEL_WIDTH  blended, saturated colour.
- m_tag  out  TAG_WIDTH  tag of the fragment in m_color.

## Operation
- Factor encoding:
  - 0 ZERO, 1 ONE, 2 DST_COLOR, 3 SRC_COLOR.
  - 4 ONE_MINUS_DST_COLOR, 5 ONE_MINUS_SRC_COLOR.
  - 6 SRC_ALPHA, 7 ONE_MINUS_SRC_ALPHA, 8 DST_ALPHA, 9 ONE_MINUS_DST_ALPHA.
  - 10 SRC_ALPHA_SATURATE.
  - 11–15 behave as ZERO.
- 1.0 is all-ones per channel. ONE_MINUS_x is the bitwise inverse of x. ALPHA factors replicate the alpha channel to all four channels.
- SRC_ALPHA_SATURATE: RGB channels get min(As, ~Ad); the alpha channel gets 1.0.
- Stage S0 (this block) registers the mixer inputs: colorA = src, colorB = Fs, colorC = dst, colorD = Fd.
- blend_enable = 0 forces Fs = ONE and Fd = ZERO, so the result is exactly src. The mixer's +1.0 rounding makes x·255+255 >> 8 = x.
- Config (blend_enable, src_factor, dst_factor) is sampled with each accepted fragment. A change takes effect from the next accepted fragment; in-flight fragments are unaffected.
- Three-entry valid shift register v[0..2] and tag shift register, aligned with S0, mixer stage 1 and mixer stage 2. m_valid = v[2], m_tag = tag[2], m_color = mixer output.
- Single global advance enable: adv = !v[2] || m_ready.
  - adv drives the S0 register enable, the mixer ce, and both shift registers.
  - s_ready = adv.
- On adv, v[0] loads s_valid. Bubbles propagate as invalid entries; no compaction.

## Timing
- Reset (async assert) clears v[2:0]; m_valid = 0, s_ready = 1, m_color/m_tag = 0.
- Mixer internal registers are unreset; their contents are don't-care while the matching valid bit is 0.
- Latency: accepted at edge N → m_valid at edge N+3 when unstalled. Throughput: 1 fragment/cycle.
- Stall: m_valid && !m_ready freezes all stages and deasserts s_ready in the same cycle (combinational). m_color and m_tag stay stable until accepted.
- Simultaneous m_ready and s_valid with a full pipe: output retires and input enters in the same cycle; no loss, no duplication.
- Reset mid-stream discards all in-flight fragments; the first post-reset output is the first post-reset acceptance.

## Structure
- Shared package/header: factor encoding constants (BLEND_ZERO … BLEND_SRC_ALPHA_SATURATE), channel position constants, and the ONE/ZERO pixel constants.
- Factor selection as one function (factor code, src, dst → factor pixel), used twice.
- Sub-module: the existing ColorMixer (2-cycle, ce-gated), instantiated once. No other sub-modules.

## Test plan
- Reset during traffic: after release, m_valid = 0 and s_ready = 1; nothing emerges until new input arrives, then the first output appears 3 cycles after it.
- blend_enable = 0, src 0x80402010, dst 0x11223344 → m_color 0x80402010, 3 cycles after accept, tag preserved.
- ONE/ZERO → src exact; ZERO/ONE with same data → 0x11223344.
- SRC_ALPHA/ONE_MINUS_SRC_ALPHA, src 0xFF000080, dst 0x00FF0000 → 0x807F0040.
- ONE/ONE, src 0xC0C0C0C0, dst 0x80808080 → 0xFFFFFFFF (saturation on all channels).
- Random m_ready backpressure with 200 back-to-back fragments (config changing per fragment) → outputs in order, tags unique and complete, m_color/m_tag stable while stalled, results match a software model.

Source files
------------

// File: rtl/blend_factor_stage_pkg.sv
// blend_factor_stage_pkg
//   Shared definitions for the fragment blending front end:
//   - blend factor encoding (BLEND_ZERO .. BLEND_SRC_ALPHA_SATURATE);
//     codes 11-15 are not listed and select ZERO
//   - channel lane positions inside a pixel (R is the most significant lane)
//   - wide all-ones / all-zeros pixel constants, sliced to the pixel width
//     by each user
package blend_factor_stage_pkg;

  typedef enum logic [3:0] {
    BLEND_ZERO                = 4'd0,
    BLEND_ONE                 = 4'd1,
    BLEND_DST_COLOR           = 4'd2,
    BLEND_SRC_COLOR           = 4'd3,
    BLEND_ONE_MINUS_DST_COLOR = 4'd4,
    BLEND_ONE_MINUS_SRC_COLOR = 4'd5,
    BLEND_SRC_ALPHA           = 4'd6,
    BLEND_ONE_MINUS_SRC_ALPHA = 4'd7,
    BLEND_DST_ALPHA           = 4'd8,
    BLEND_ONE_MINUS_DST_ALPHA = 4'd9,
    BLEND_SRC_ALPHA_SATURATE  = 4'd10
  } blend_factor_e;

  localparam int NUM_CHANNELS = 4;

  // Lane index of each channel; lane i occupies bits [i*W +: W].
  localparam int CH_R = 3;
  localparam int CH_G = 2;
  localparam int CH_B = 1;
  localparam int CH_A = 0;

  // Large enough for any sensible channel width; users take the low bits.
  localparam int MAX_PIXEL_WIDTH = 256;
  localparam logic [MAX_PIXEL_WIDTH-1:0] PIXEL_ONE  = '1;
  localparam logic [MAX_PIXEL_WIDTH-1:0] PIXEL_ZERO = '0;

endpackage

// File: rtl/blend_factor_stage_color_mixer.sv
// blend_factor_stage_color_mixer
//   The existing two-cycle ColorMixer. Per channel it computes
//   a*b + c*d + 1.0 (all-ones), keeps the integer part (>> W) and
//   saturates to 1.0. The +1.0 rounding term makes x*1.0 + 0 return x.
//   Stage 1 registers the two products, stage 2 registers the saturated
//   sum. Both stages advance only while ce is high; registers are unreset.
// Ports:
//   aclk       clock
//   ce         clock enable for both stages
//   color_a..d four-channel operands (a*b + c*d)
//   color_out  saturated result, two ce-cycles after the operands
module blend_factor_stage_color_mixer
  import blend_factor_stage_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = 8
) (
  input  logic                                 aclk,
  input  logic                                 ce,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] color_a,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] color_b,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] color_c,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] color_d,
  output logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] color_out
);

  localparam int W       = SUB_PIXEL_WIDTH;
  localparam int PIXEL_W = NUM_CHANNELS * W;
  localparam int PROD_W  = 2 * W;
  // Two full-scale products plus the rounding term still fit in 2W+1 bits.
  localparam int SUM_W   = 2 * W + 1;
  localparam logic [W-1:0] CH_ONE = '1;

  logic [PROD_W-1:0]  prod_ab [NUM_CHANNELS];
  logic [PROD_W-1:0]  prod_cd [NUM_CHANNELS];
  logic [PIXEL_W-1:0] next_out;

  // Stage 1: per-channel products.
  always_ff @(posedge aclk) begin
    if (ce) begin
      for (int i = 0; i < NUM_CHANNELS; i++) begin
        prod_ab[i] <= PROD_W'(color_a[i*W +: W]) * PROD_W'(color_b[i*W +: W]);
        prod_cd[i] <= PROD_W'(color_c[i*W +: W]) * PROD_W'(color_d[i*W +: W]);
      end
    end
  end

  // Sum, round by +1.0, drop the fraction and clamp to 1.0.
  always_comb begin
    logic [SUM_W-1:0] sum;
    logic [W:0]       scaled;
    next_out = '0;
    sum      = '0;
    scaled   = '0;
    for (int i = 0; i < NUM_CHANNELS; i++) begin
      sum    = SUM_W'(prod_ab[i]) + SUM_W'(prod_cd[i]) + SUM_W'(CH_ONE);
      scaled = sum[SUM_W-1:W];
      next_out[i*W +: W] = scaled[W] ? CH_ONE : scaled[W-1:0];
    end
  end

  // Stage 2: saturated result.
  always_ff @(posedge aclk) begin
    if (ce) begin
      color_out <= next_out;
    end
  end

endmodule

// File: rtl/blend_factor_stage.sv
// blend_factor_stage
//   Fragment blending front end. Accepts one fragment per cycle, picks the
//   source and destination blend factors, registers the mixer operands
//   (stage S0) and runs them through the two-cycle color mixer. Valid and
//   tag travel in a three-entry shift register aligned with S0 and the two
//   mixer stages. A single advance enable moves every stage at once, so a
//   stalled output freezes the whole pipe and drops s_ready combinationally.
// Ports:
//   aclk, reset               clock, asynchronous active-high reset
//   blend_enable              0: pass src through, 1: blend
//   src_factor, dst_factor    blend factor codes, sampled per accepted fragment
//   s_valid/s_ready           input handshake
//   s_src, s_dst, s_tag       source colour, destination colour, sideband
//   m_valid/m_ready           output handshake
//   m_color, m_tag            blended colour and sideband of the output fragment
module blend_factor_stage
  import blend_factor_stage_pkg::*;
#(
  parameter int SUB_PIXEL_WIDTH = 8,
  parameter int TAG_WIDTH       = 16
) (
  input  logic                                 aclk,
  input  logic                                 reset,
  input  logic                                 blend_enable,
  input  logic [3:0]                           src_factor,
  input  logic [3:0]                           dst_factor,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] s_src,
  input  logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] s_dst,
  input  logic [TAG_WIDTH-1:0]                 s_tag,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [NUM_CHANNELS*SUB_PIXEL_WIDTH-1:0] m_color,
  output logic [TAG_WIDTH-1:0]                 m_tag
);

  localparam int W       = SUB_PIXEL_WIDTH;
  localparam int PIXEL_W = NUM_CHANNELS * W;
  localparam logic [PIXEL_W-1:0] ONE_PIXEL  = PIXEL_ONE[PIXEL_W-1:0];
  localparam logic [PIXEL_W-1:0] ZERO_PIXEL = PIXEL_ZERO[PIXEL_W-1:0];

  // Factor pixel for one blend code. ONE_MINUS_x is the bitwise inverse of x;
  // alpha factors replicate the alpha lane; unknown codes give ZERO.
  function automatic logic [PIXEL_W-1:0] select_factor(
    input logic [3:0]         code,
    input logic [PIXEL_W-1:0] src,
    input logic [PIXEL_W-1:0] dst
  );
    logic [W-1:0]       src_a;
    logic [W-1:0]       inv_dst_a;
    logic [W-1:0]       sat;
    logic [PIXEL_W-1:0] f;
    src_a     = src[CH_A*W +: W];
    inv_dst_a = ~dst[CH_A*W +: W];
    sat       = (src_a < inv_dst_a) ? src_a : inv_dst_a;
    case (code)
      BLEND_ZERO:                f = ZERO_PIXEL;
      BLEND_ONE:                 f = ONE_PIXEL;
      BLEND_DST_COLOR:           f = dst;
      BLEND_SRC_COLOR:           f = src;
      BLEND_ONE_MINUS_DST_COLOR: f = ~dst;
      BLEND_ONE_MINUS_SRC_COLOR: f = ~src;
      BLEND_SRC_ALPHA:           f = {NUM_CHANNELS{src_a}};
      BLEND_ONE_MINUS_SRC_ALPHA: f = {NUM_CHANNELS{~src_a}};
      BLEND_DST_ALPHA:           f = {NUM_CHANNELS{~inv_dst_a}};
      BLEND_ONE_MINUS_DST_ALPHA: f = {NUM_CHANNELS{inv_dst_a}};
      BLEND_SRC_ALPHA_SATURATE: begin
        f = ZERO_PIXEL;
        f[CH_R*W +: W] = sat;
        f[CH_G*W +: W] = sat;
        f[CH_B*W +: W] = sat;
        f[CH_A*W +: W] = '1;
      end
      default:                   f = ZERO_PIXEL;
    endcase
    return f;
  endfunction

  logic                 adv;
  logic [2:0]           v_q;
  logic [TAG_WIDTH-1:0] tag_q [3];
  logic [PIXEL_W-1:0]   fs;
  logic [PIXEL_W-1:0]   fd;
  logic [PIXEL_W-1:0]   color_a_q;
  logic [PIXEL_W-1:0]   color_b_q;
  logic [PIXEL_W-1:0]   color_c_q;
  logic [PIXEL_W-1:0]   color_d_q;
  logic [PIXEL_W-1:0]   mix_color;

  // The whole pipe moves unless the output holds a fragment nobody takes.
  assign adv     = !v_q[2] || m_ready;
  assign s_ready = adv;

  // Blending disabled means src*1.0 + dst*0, which the mixer returns as src.
  always_comb begin
    fs = ONE_PIXEL;
    fd = ZERO_PIXEL;
    if (blend_enable) begin
      fs = select_factor(src_factor, s_src, s_dst);
      fd = select_factor(dst_factor, s_src, s_dst);
    end
  end

  // Valid and tag shift registers; bubbles travel as invalid entries.
  always_ff @(posedge aclk or posedge reset) begin
    if (reset) begin
      v_q      <= '0;
      tag_q[0] <= '0;
      tag_q[1] <= '0;
      tag_q[2] <= '0;
    end else if (adv) begin
      v_q      <= {v_q[1:0], s_valid};
      tag_q[0] <= s_tag;
      tag_q[1] <= tag_q[0];
      tag_q[2] <= tag_q[1];
    end
  end

  // S0 operand registers; contents only matter while v_q[0] is set.
  always_ff @(posedge aclk) begin
    if (adv) begin
      color_a_q <= s_src;
      color_b_q <= fs;
      color_c_q <= s_dst;
      color_d_q <= fd;
    end
  end

  blend_factor_stage_color_mixer #(
    .SUB_PIXEL_WIDTH (SUB_PIXEL_WIDTH)
  ) u_mixer (
    .aclk      (aclk),
    .ce        (adv),
    .color_a   (color_a_q),
    .color_b   (color_b_q),
    .color_c   (color_c_q),
    .color_d   (color_d_q),
    .color_out (mix_color)
  );

  // Mixer registers are unreset, so outputs are masked until a valid result.
  assign m_valid = v_q[2];
  assign m_color = v_q[2] ? mix_color : ZERO_PIXEL;
  assign m_tag   = v_q[2] ? tag_q[2]  : '0;

endmodule

// File: tb/tb_blend_factor_stage.sv
// tb_blend_factor_stage
//   Directed and randomised checks of blend_factor_stage with a scoreboard
//   queue: expected {colour, tag} is pushed when a fragment is accepted and
//   popped when the output handshake completes.
module tb_blend_factor_stage;

  logic        aclk = 1'b0;
  logic        reset = 1'b1;
  logic        blend_enable = 1'b0;
  logic [3:0]  src_factor = 4'd0;
  logic [3:0]  dst_factor = 4'd0;
  logic        s_valid = 1'b0;
  logic        s_ready;
  logic [31:0] s_src = 32'h0;
  logic [31:0] s_dst = 32'h0;
  logic [15:0] s_tag = 16'h0;
  logic        m_valid;
  logic        m_ready = 1'b1;
  logic [31:0] m_color;
  logic [15:0] m_tag;

  int          total = 0;
  int          bad = 0;
  logic [47:0] sb [$];
  logic        randomReady = 1'b0;
  logic        prevStall = 1'b0;
  logic [31:0] prevColor = 32'h0;
  logic [15:0] prevTag = 16'h0;

  blend_factor_stage #(
    .SUB_PIXEL_WIDTH (8),
    .TAG_WIDTH       (16)
  ) dut (
    .aclk         (aclk),
    .reset        (reset),
    .blend_enable (blend_enable),
    .src_factor   (src_factor),
    .dst_factor   (dst_factor),
    .s_valid      (s_valid),
    .s_ready      (s_ready),
    .s_src        (s_src),
    .s_dst        (s_dst),
    .s_tag        (s_tag),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .m_color      (m_color),
    .m_tag        (m_tag)
  );

  always #5 aclk = ~aclk;

  // One comparison: counts it, and reports a failure with both values.
  task automatic checkOutput(input string name, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("[TB] FAIL %s: got %h, required %h", name, obs, exp);
    end
  endtask

  // Reference factor for one channel, written in plain integer arithmetic.
  function automatic int facModel(input int code, input int ch, input logic [31:0] src, input logic [31:0] dst);
    int sc, dc, sa, da;
    sc = int'(src[ch*8 +: 8]);
    dc = int'(dst[ch*8 +: 8]);
    sa = int'(src[7:0]);
    da = int'(dst[7:0]);
    case (code)
      1:  return 255;
      2:  return dc;
      3:  return sc;
      4:  return 255 - dc;
      5:  return 255 - sc;
      6:  return sa;
      7:  return 255 - sa;
      8:  return da;
      9:  return 255 - da;
      10: return (ch == 0) ? 255 : ((sa < 255 - da) ? sa : 255 - da);
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] model(input logic [31:0] src, input logic [31:0] dst,
                                        input logic en, input logic [3:0] sf, input logic [3:0] df);
    logic [31:0] r;
    int sc, dc, fs, fd, acc;
    r = 32'h0;
    for (int ch = 0; ch < 4; ch++) begin
      sc  = int'(src[ch*8 +: 8]);
      dc  = int'(dst[ch*8 +: 8]);
      fs  = en ? facModel(int'(sf), ch, src, dst) : 255;
      fd  = en ? facModel(int'(df), ch, src, dst) : 0;
      acc = (sc * fs + dc * fd + 255) / 256;
      if (acc > 255) acc = 255;
      r[ch*8 +: 8] = 8'(acc);
    end
    return r;
  endfunction

  task automatic stepCycle;
    @(posedge aclk);
    #1;
  endtask

  // Called at posedge+1; presents one fragment until accepted, pushes the
  // expected result and returns at posedge+1 after the accepting edge.
  task automatic applyStimulus(input logic [31:0] src, input logic [31:0] dst, input logic [15:0] tag,
                               input logic en, input logic [3:0] sf, input logic [3:0] df,
                               input logic [31:0] exp);
    int waitCycles;
    logic accepted;
    waitCycles   = 0;
    accepted     = 1'b0;
    s_valid      = 1'b1;
    s_src        = src;
    s_dst        = dst;
    s_tag        = tag;
    blend_enable = en;
    src_factor   = sf;
    dst_factor   = df;
    while (!accepted && waitCycles <= 1000) begin
      @(negedge aclk);
      if (s_ready) accepted = 1'b1;
      else waitCycles++;
      if (!accepted) stepCycle();
    end
    if (!accepted) checkOutput("accept_timeout", 64'(waitCycles), 64'd0);
    else begin
      sb.push_back({exp, tag});
      stepCycle();
    end
    s_valid = 1'b0;
  endtask

  // Number of edges from acceptance to the output transfer (m_ready held 1).
  task automatic checkLatency(input string name);
    int n;
    n = 0;
    @(negedge aclk);
    while (!m_valid && n < 10) begin
      @(negedge aclk);
      n++;
    end
    checkOutput(name, 64'(n + 1), 64'd3);
  endtask

  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 2000) begin
      stepCycle();
      n++;
    end
    checkOutput(name, 64'(sb.size()), 64'd0);
  endtask

  // Output monitor: scoreboard pops on transfer, stability checks on stall.
  initial forever begin
    logic [47:0] e;
    @(negedge aclk);
    if (reset) begin
      prevStall = 1'b0;
    end else begin
      if (prevStall) begin
        checkOutput("stall_valid", 64'(m_valid), 64'd1);
        checkOutput("stall_color", 64'(m_color), 64'(prevColor));
        checkOutput("stall_tag", 64'(m_tag), 64'(prevTag));
      end
      if (m_valid && m_ready) begin
        total++;
        assert (sb.size() != 0) else begin
          bad++;
          $error("[TB] FAIL unexpected_output: got tag %h, required no output", m_tag);
        end
        if (sb.size() != 0) begin
          e = sb.pop_front();
          checkOutput("out_color", 64'(m_color), 64'(e[47:16]));
          checkOutput("out_tag", 64'(m_tag), 64'(e[15:0]));
        end
      end
      prevStall = m_valid && !m_ready;
      prevColor = m_color;
      prevTag   = m_tag;
    end
  end

  // Random output backpressure while enabled.
  initial forever begin
    @(posedge aclk);
    #1;
    if (randomReady) m_ready = ($urandom_range(0, 3) != 0);
  end

  initial begin
    logic [31:0] rs, rd;
    logic        ren;
    logic [3:0]  rsf, rdf;
    int          seen;

    $display("[TB] start");
    reset = 1'b1;
    repeat (3) stepCycle();
    checkOutput("reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("reset_s_ready", 64'(s_ready), 64'd1);
    checkOutput("reset_m_color", 64'(m_color), 64'd0);
    checkOutput("reset_m_tag", 64'(m_tag), 64'd0);
    reset = 1'b0;
    stepCycle();

    // Pass-through with blending off; factor codes must be ignored.
    applyStimulus(32'h80402010, 32'h11223344, 16'hA001, 1'b0, 4'd0, 4'd1, 32'h80402010);
    checkLatency("latency_bypass");
    stepCycle();

    // Directed factor cases, back to back.
    applyStimulus(32'h80402010, 32'h11223344, 16'hA002, 1'b1, 4'd1, 4'd0, 32'h80402010);
    applyStimulus(32'h80402010, 32'h11223344, 16'hA003, 1'b1, 4'd0, 4'd1, 32'h11223344);
    applyStimulus(32'hFF000080, 32'h00FF0000, 16'hA004, 1'b1, 4'd6, 4'd7, 32'h807F0040);
    applyStimulus(32'hC0C0C0C0, 32'h80808080, 16'hA005, 1'b1, 4'd1, 4'd1, 32'hFFFFFFFF);
    applyStimulus(32'h40808020, 32'h000000F0, 16'hA006, 1'b1, 4'd10, 4'd0, 32'h04080820);
    applyStimulus(32'h55555555, 32'h01020304, 16'hA007, 1'b1, 4'd12, 4'd1, 32'h01020304);
    applyStimulus(32'hFFFFFFFF, 32'h12345678, 16'hA008, 1'b1, 4'd2, 4'd0, 32'h12345678);
    waitDrain("drain_directed");

    // Fill the pipe under a stall, then reset in the middle of it.
    m_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rs = $urandom();
      rd = $urandom();
      applyStimulus(rs, rd, 16'hB000 + 16'(i), 1'b1, 4'd1, 4'd1, model(rs, rd, 1'b1, 4'd1, 4'd1));
    end
    checkOutput("full_stall_s_ready", 64'(s_ready), 64'd0);
    checkOutput("full_stall_m_valid", 64'(m_valid), 64'd1);
    reset = 1'b1;
    sb.delete();
    #1;
    checkOutput("async_reset_m_valid", 64'(m_valid), 64'd0);
    stepCycle();
    stepCycle();
    reset = 1'b0;
    stepCycle();
    checkOutput("post_reset_m_valid", 64'(m_valid), 64'd0);
    checkOutput("post_reset_s_ready", 64'(s_ready), 64'd1);
    m_ready = 1'b1;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge aclk);
      if (m_valid) seen++;
    end
    checkOutput("post_reset_idle", 64'(seen), 64'd0);
    stepCycle();
    applyStimulus(32'h80402010, 32'h11223344, 16'hC001, 1'b1, 4'd6, 4'd7,
                  model(32'h80402010, 32'h11223344, 1'b1, 4'd6, 4'd7));
    checkLatency("latency_post_reset");
    stepCycle();
    waitDrain("drain_post_reset");

    // 200 back-to-back fragments with per-fragment config and random m_ready.
    randomReady = 1'b1;
    for (int i = 0; i < 200; i++) begin
      rs  = $urandom();
      rd  = $urandom();
      ren = ($urandom_range(0, 4) != 0);
      rsf = 4'($urandom_range(0, 15));
      rdf = 4'($urandom_range(0, 15));
      applyStimulus(rs, rd, 16'h1000 + 16'(i), ren, rsf, rdf, model(rs, rd, ren, rsf, rdf));
    end
    randomReady = 1'b0;
    stepCycle();
    m_ready = 1'b1;
    waitDrain("drain_random");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
